// File: rtl/issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// issue_queue_pkg
// Shared types and default sizing for the in-order issue queue.
//   scoreboard_entry_t : decoded instruction carried from rename to the FUs
//   issue_q_entry_t    : one queue slot (instruction + target channel index)
//   ISSUE_Q_DEPTH / NR_ISSUE_FU / ISSUE_MAX_OUTST : default queue geometry
//   sel_width()        : width of a channel index for a given channel count
// Optional build macro used by the queue: ISSUE_QUEUE_BYPASS_EN
// -----------------------------------------------------------------------------
package issue_queue_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [7:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } scoreboard_entry_t;

   // Channel index width, never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ISSUE_Q_DEPTH   = 4;
   localparam int NR_ISSUE_FU     = 4;
   localparam int ISSUE_MAX_OUTST = 2;
   localparam int FU_SEL_W        = sel_width(NR_ISSUE_FU);
   localparam int OUTST_W         = $clog2(ISSUE_MAX_OUTST + 1);

   typedef struct packed {
      scoreboard_entry_t     sbe;
      logic [FU_SEL_W-1:0]   fu;
   } issue_q_entry_t;

endpackage

// File: rtl/fu_credit_counter.sv
// -----------------------------------------------------------------------------
// fu_credit_counter
// Saturating up/down counter of in-flight operations for one FU channel.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   clear_i  : synchronous clear to zero (dominates inc/dec)
//   inc_i    : one op dispatched to this channel
//   dec_i    : one op retired by this channel
//   count_o  : current in-flight count, saturates at 0 and MAX_VAL
// -----------------------------------------------------------------------------
module fu_credit_counter
   import issue_queue_pkg::*;
#(
   parameter int MAX_VAL = ISSUE_MAX_OUTST,
   parameter int W       = $clog2(MAX_VAL + 1)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   // NOTE: clocked state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (inc_i && !dec_i) begin
         if (count_q != W'(MAX_VAL)) count_q <= count_q + W'(1);
      end else if (dec_i && !inc_i) begin
         if (count_q != '0) count_q <= count_q - W'(1);
      end
   end

   // A retire with nothing in flight is ignored by the counter but is a
   // protocol error on the FU side.
   always @(posedge clk_i) begin
      assert (rst_i || clear_i || !(dec_i && !inc_i && count_q == '0))
         else $error("fu_credit_counter: retire with no op in flight");
   end

   assign count_o = count_q;

endmodule

// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
// In-order issue buffer between rename and the functional units. Holds DEPTH
// decoded instructions and dispatches the head to one of NR_FU valid/ready
// channels, limiting each channel to MAX_OUTST operations in flight.
//   clk_i / rst_i        : clock, asynchronous active-high reset
//   flush_unissued_i     : drop every queued entry, keep in-flight counts
//   flush_i              : drop every queued entry and clear in-flight counts
//   instr_i/instr_fu_i   : incoming instruction and its target channel
//   instr_valid_i/ready_o: enqueue handshake (ready = not full)
//   issue_instr_o        : head instruction, shared by all channels
//   issue_valid_o        : one-hot valid toward the head's channel
//   fu_ready_i           : per-channel accept
//   fu_done_i            : per-channel retire pulse (one per op)
//   empty_o / full_o     : occupancy flags
//   outst_o              : per-channel in-flight count
// Build option: define ISSUE_QUEUE_BYPASS_EN to let an incoming instruction
// issue in the same cycle when the queue is empty.
// -----------------------------------------------------------------------------
module issue_queue
   import issue_queue_pkg::*;
#(
   parameter  int DEPTH     = ISSUE_Q_DEPTH,
   parameter  int NR_FU     = NR_ISSUE_FU,
   parameter  int MAX_OUTST = ISSUE_MAX_OUTST,
   localparam int FU_W      = sel_width(NR_FU),
   localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_unissued_i,
   input  logic                        flush_i,
   input  scoreboard_entry_t           instr_i,
   input  logic [FU_W-1:0]             instr_fu_i,
   input  logic                        instr_valid_i,
   output logic                        instr_ready_o,
   output scoreboard_entry_t           issue_instr_o,
   output logic [NR_FU-1:0]            issue_valid_o,
   input  logic [NR_FU-1:0]            fu_ready_i,
   input  logic [NR_FU-1:0]            fu_done_i,
   output logic                        empty_o,
   output logic                        full_o,
   output logic [NR_FU-1:0][CNT_W-1:0] outst_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef struct packed {
      scoreboard_entry_t sbe;
      logic [FU_W-1:0]   fu;
   } entry_t;

   entry_t                      mem_q [DEPTH];
   logic [PTR_W-1:0]            rd_ptr_q;
   logic [PTR_W-1:0]            wr_ptr_q;
   logic [OCC_W-1:0]            count_q;
   logic [NR_FU-1:0][CNT_W-1:0] outst;

   entry_t           head;
   entry_t           sel;
   logic             empty;
   logic             full;
   logic             flush_any;
   logic             use_bypass;
   logic             sel_present;
   logic             sel_fu_ok;
   logic [CNT_W-1:0] sel_outst;
   logic             can_issue;
   logic [NR_FU-1:0] dispatch_vec;
   logic             dispatch;
   logic             drop;
   logic             deq;
   logic             enq;
   logic             bypass_taken;

   assign empty     = (count_q == '0);
   assign full      = (count_q == OCC_W'(DEPTH));
   assign flush_any = flush_i || flush_unissued_i;
   assign head      = mem_q[rd_ptr_q];

`ifdef ISSUE_QUEUE_BYPASS_EN
   assign use_bypass = empty && instr_valid_i;
`else
   assign use_bypass = 1'b0;
`endif

   // Candidate for issue: the queue head, or the incoming instruction when
   // the bypass path is active on an empty queue.
   // NOTE: every signal driven in an always_comb gets a default first, so no
   // path through the block leaves it holding an old value (no latch).
   always_comb begin
      sel         = head;
      sel_present = !empty;
      if (use_bypass) begin
         sel.sbe     = instr_i;
         sel.fu      = instr_fu_i;
         sel_present = 1'b1;
      end
   end

   // Index widened before the compare so a non-power-of-two NR_FU can flag
   // out-of-range channel numbers.
   assign sel_fu_ok = (32'(sel.fu) < 32'(NR_FU));

   always_comb begin
      sel_outst = '0;
      for (int c = 0; c < NR_FU; c++) begin
         if (sel.fu == FU_W'(c)) sel_outst = outst[c];
      end
   end

   // Only registered state (plus instr_i on the bypass path) feeds valid;
   // fu_ready_i never does.
   assign can_issue = sel_present && sel_fu_ok && (32'(sel_outst) < 32'(MAX_OUTST));

   always_comb begin
      issue_valid_o = '0;
      for (int c = 0; c < NR_FU; c++) begin
         issue_valid_o[c] = can_issue && (sel.fu == FU_W'(c));
      end
   end

   assign dispatch_vec = issue_valid_o & fu_ready_i;
   assign dispatch     = |dispatch_vec;

   // A queued head with an impossible channel index is discarded, one entry
   // per cycle. The bypass path is only active on an empty queue, so a
   // non-empty queue always presents its head here.
   assign drop         = !empty && !sel_fu_ok;
   assign deq          = (!empty && dispatch) || drop;
   assign bypass_taken = use_bypass && dispatch;
   assign enq          = instr_valid_i && instr_ready_o && !bypass_taken;

   assign instr_ready_o = !full;
   assign issue_instr_o = sel_present ? sel.sbe : '0;
   assign empty_o       = empty;
   assign full_o        = full;
   assign outst_o       = outst;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_any) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + OCC_W'(enq) - OCC_W'(deq);
      end
   end

   // NOTE: the storage array has no reset; pointers and count alone decide
   // which slots hold live data, and the head output is masked when empty.
   always_ff @(posedge clk_i) begin
      if (enq && !flush_any) mem_q[wr_ptr_q] <= '{sbe: instr_i, fu: instr_fu_i};
   end

   // A dispatch in a flush_unissued_i cycle still reached the FU, so it is
   // counted; flush_i wipes every counter regardless.
   for (genvar c = 0; c < NR_FU; c++) begin : g_credit
      fu_credit_counter #(
         .MAX_VAL (MAX_OUTST),
         .W       (CNT_W)
      ) u_credit (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .clear_i (flush_i),
         .inc_i   (dispatch_vec[c]),
         .dec_i   (fu_done_i[c]),
         .count_o (outst[c])
      );
   end

   always @(posedge clk_i) begin
      assert (rst_i || !drop)
         else $error("issue_queue: head entry with invalid fu index dropped");
   end

endmodule

// File: tb/tb_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_queue
// Directed bench for issue_queue with default geometry (DEPTH=4, NR_FU=4,
// MAX_OUTST=2). Accepted instructions are pushed to an expected-result queue
// and popped whenever a channel takes the head; occupancy and credit counts
// are compared against constants at each step.
// -----------------------------------------------------------------------------
module tb_issue_queue;
   import issue_queue_pkg::*;

   logic                               clk = 1'b0;
   logic                               rst;
   logic                               flush_unissued;
   logic                               flush;
   scoreboard_entry_t                  instr;
   logic [FU_SEL_W-1:0]                instr_fu;
   logic                               instr_valid;
   logic                               instr_ready;
   scoreboard_entry_t                  issue_instr;
   logic [NR_ISSUE_FU-1:0]             issue_valid;
   logic [NR_ISSUE_FU-1:0]             fu_ready;
   logic [NR_ISSUE_FU-1:0]             fu_done;
   logic                               empty;
   logic                               full;
   logic [NR_ISSUE_FU-1:0][OUTST_W-1:0] outst;

   issue_q_entry_t exp_q[$];
   int total  = 0;
   int bad    = 0;
   int n_disp = 0;

   always #5 clk = ~clk;

   issue_queue dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .flush_unissued_i (flush_unissued),
      .flush_i          (flush),
      .instr_i          (instr),
      .instr_fu_i       (instr_fu),
      .instr_valid_i    (instr_valid),
      .instr_ready_o    (instr_ready),
      .issue_instr_o    (issue_instr),
      .issue_valid_o    (issue_valid),
      .fu_ready_i       (fu_ready),
      .fu_done_i        (fu_done),
      .empty_o          (empty),
      .full_o           (full),
      .outst_o          (outst)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic scoreboard_entry_t mk(input int k);
      scoreboard_entry_t e;
      e.pc  = 32'h1000 + 32'(k) * 32'd4;
      e.op  = 8'(k * 3 + 1);
      e.rd  = 5'(k + 1);
      e.rs1 = 5'(k + 2);
      e.rs2 = 5'(k + 7);
      return e;
   endfunction

   task automatic offer(input int k, input int fu);
      instr       = mk(k);
      instr_fu    = FU_SEL_W'(fu);
      instr_valid = 1'b1;
   endtask

   // One clock: settle, record enqueue / compare any dispatch, then advance
   // to the next falling edge where inputs are changed.
   task automatic cycle();
      issue_q_entry_t e;
      #1;
      if (instr_valid && instr_ready && !flush && !flush_unissued) begin
         e.sbe = instr;
         e.fu  = instr_fu;
         exp_q.push_back(e);
      end
      if (|(issue_valid & fu_ready)) begin
         n_disp++;
         if (exp_q.size() == 0) begin
            check("disp_unexpected", 64'(issue_valid), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("disp_instr", 64'(issue_instr), 64'(e.sbe));
            check("disp_chan", 64'(issue_valid), 64'(NR_ISSUE_FU'(1) << e.fu));
         end
      end
      if (flush || flush_unissued) exp_q.delete();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst            = 1'b1;
      flush          = 1'b0;
      flush_unissued = 1'b0;
      instr          = '0;
      instr_fu       = '0;
      instr_valid    = 1'b0;
      fu_ready       = '0;
      fu_done        = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_full", 64'(full), 64'(0));
      check("rst_ready", 64'(instr_ready), 64'(1));
      check("rst_valid", 64'(issue_valid), 64'(0));
      check("rst_instr", 64'(issue_instr), 64'(0));
      check("rst_outst", 64'(outst), 64'(0));

      // In-order dispatch to four channels, all ready.
      fu_ready = 4'hF;
      for (int k = 0; k < 4; k++) begin
         offer(k, k);
         cycle();
      end
      instr_valid = 1'b0;
      cycle();
      cycle();
      check("t1_empty", 64'(empty), 64'(1));
      check("t1_valid", 64'(issue_valid), 64'(0));
      check("t1_outst", 64'(outst), 64'h55);
      check("t1_ndisp", 64'(n_disp), 64'(4));
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      check("t1_flush_outst", 64'(outst), 64'(0));

      // Fill to full with every channel stalled; fifth offer must wait.
      fu_ready = 4'h0;
      for (int k = 4; k < 8; k++) begin
         offer(k, k - 4);
         cycle();
      end
      check("t2_full", 64'(full), 64'(1));
      check("t2_ready", 64'(instr_ready), 64'(0));
      check("t2_valid_no_ready", 64'(issue_valid), 64'h1);
      offer(8, 0);
      cycle();
      check("t2_held_full", 64'(full), 64'(1));
      check("t2_held_ready", 64'(instr_ready), 64'(0));
      fu_ready = 4'b0001;
      cycle();
      fu_ready = 4'h0;
      check("t2_deq_full", 64'(full), 64'(0));
      check("t2_deq_ready", 64'(instr_ready), 64'(1));
      check("t2_deq_outst", 64'(outst), 64'h01);
      cycle();
      check("t2_refill_full", 64'(full), 64'(1));
      check("t2_next_head", 64'(issue_valid), 64'h2);
      instr_valid = 1'b0;
      fu_ready    = 4'hF;
      repeat (4) cycle();
      check("t2_empty", 64'(empty), 64'(1));
      check("t2_outst", 64'(outst), 64'h56);
      check("t2_ndisp", 64'(n_disp), 64'(9));
      flush = 1'b1;
      cycle();
      flush = 1'b0;

      // Credit limit on channel 1.
      fu_ready = 4'b0010;
      for (int k = 10; k < 13; k++) begin
         offer(k, 1);
         cycle();
      end
      instr_valid = 1'b0;
      cycle();
      check("t3_blocked_valid", 64'(issue_valid), 64'(0));
      check("t3_blocked_outst", 64'(outst), 64'h08);
      check("t3_blocked_empty", 64'(empty), 64'(0));
      fu_done = 4'b0010;
      cycle();
      fu_done = 4'b0000;
      check("t3_done_outst", 64'(outst), 64'h04);
      check("t3_done_valid", 64'(issue_valid), 64'h2);
      cycle();
      check("t3_issued_empty", 64'(empty), 64'(1));
      check("t3_issued_outst", 64'(outst), 64'h08);
      fu_done = 4'b0010;
      cycle();
      cycle();
      fu_done = 4'b0000;
      check("t3_drain_outst", 64'(outst), 64'(0));

      // In-order stall: head targets busy ch2, younger targets ready ch0.
      fu_ready = 4'b0001;
      offer(20, 2);
      cycle();
      offer(21, 0);
      cycle();
      instr_valid = 1'b0;
      cycle();
      check("t4_stall_valid", 64'(issue_valid), 64'h4);
      check("t4_stall_empty", 64'(empty), 64'(0));
      check("t4_stall_outst", 64'(outst), 64'(0));
      cycle();
      check("t4_stall_hold", 64'(issue_valid), 64'h4);
      check("t4_stall_ndisp", 64'(n_disp), 64'(12));
      fu_ready = 4'b0101;
      cycle();
      cycle();
      check("t4_empty", 64'(empty), 64'(1));
      check("t4_outst", 64'(outst), 64'h11);

      // Flush of unissued entries keeps credits; full flush clears them.
      fu_ready = 4'h0;
      offer(30, 1);
      cycle();
      offer(31, 1);
      cycle();
      offer(32, 3);
      cycle();
      instr_valid = 1'b0;
      check("t5_queued_empty", 64'(empty), 64'(0));
      check("t5_queued_full", 64'(full), 64'(0));
      flush_unissued = 1'b1;
      cycle();
      flush_unissued = 1'b0;
      check("t5_fu_empty", 64'(empty), 64'(1));
      check("t5_fu_outst", 64'(outst), 64'h11);
      check("t5_fu_valid", 64'(issue_valid), 64'(0));
      fu_ready = 4'hF;
      cycle();
      check("t5_no_disp", 64'(n_disp), 64'(14));
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      check("t5_flush_outst", 64'(outst), 64'(0));
      check("t5_flush_empty", 64'(empty), 64'(1));

`ifdef ISSUE_QUEUE_BYPASS_EN
      // Same-cycle issue from an empty queue.
      fu_ready = 4'b1000;
      offer(40, 3);
      #1;
      check("byp_valid", 64'(issue_valid), 64'h8);
      check("byp_instr", 64'(issue_instr), 64'(mk(40)));
      cycle();
      instr_valid = 1'b0;
      check("byp_empty", 64'(empty), 64'(1));
      check("byp_outst", 64'(outst), 64'h40);
`endif

      check("sb_drained", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
